uart_frame_rx: RTL and testbench

- Downstream consumer of the UART unit's RX FIFO. Pops received bytes and hunts for a start-of-frame byte, then assembles a framed command: SOF, CMD, LEN, payload, XOR checksum.
- Presents each valid command to the debug/control logic through a valid/ready handshake.
- Answers the host with an ACK or NAK byte through the UART TX FIFO.
- Sits between the uart instance and the processor debug unit, replacing the button-driven loopback used during bring-up.

---
 rtl/uart_frame_rx_pkg.sv | 36 +++
 rtl/uart_frame_rx_if.sv | 29 ++
 rtl/uart_frame_rx_payload_buf.sv | 22 ++
 rtl/uart_frame_rx.sv | 140 ++++++++++++++
 tb/tb_uart_frame_rx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_rx_pkg.sv
// Shared definitions for the framed-command receiver: FSM states, frame field
// order and the default marker/response bytes.
package uart_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_HOLD,
        ST_RESP
    } state_t;

    // On-the-wire order: SOF, CMD, LEN, LEN payload bytes, XOR of CMD..payload.
    typedef enum logic [2:0] {
        FLD_SOF,
        FLD_CMD,
        FLD_LEN,
        FLD_DATA,
        FLD_CSUM
    } frame_field_t;

    localparam int         MAX_LEN_DEF   = 16;
    localparam int         AW_DEF        = 4;
    localparam logic [7:0] SOF_DEF       = 8'hA5;
    localparam logic [7:0] ACK_DEF       = 8'h06;
    localparam logic [7:0] NAK_DEF       = 8'h15;
    localparam int         TO_CYCLES_DEF = 100000;
    localparam int         TO_W          = 17;

    function automatic logic in_frame(state_t s);
        return (s == ST_CMD) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// UART FIFO, command handshake and payload read signals of uart_frame_rx.
// master = the frame receiver, slave = UART / debug-unit side.
interface uart_frame_rx_if #(
    parameter int AW = 4
);
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          tx_full;
    logic          wr_uart;
    logic [7:0]    w_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_code;
    logic [7:0]    cmd_len;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    logic [7:0]    err_cnt;

    modport master (
        input  rx_empty, r_data, tx_full, cmd_ready, pl_addr,
        output rd_uart, wr_uart, w_data, cmd_valid, cmd_code, cmd_len, pl_data, err_cnt
    );

    modport slave (
        output rx_empty, r_data, tx_full, cmd_ready, pl_addr,
        input  rd_uart, wr_uart, w_data, cmd_valid, cmd_code, cmd_len, pl_data, err_cnt
    );
endinterface

// File: rtl/uart_frame_rx_payload_buf.sv
// MAX_LEN x 8 payload register file: one synchronous write port, one
// combinational read port. Contents are not reset.
module frame_payload_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < MAX_LEN)) mem[waddr] <= wdata;
    end

    // Addresses past MAX_LEN (possible when 2**AW > MAX_LEN) read as zero.
    assign rdata = (int'(raddr) < MAX_LEN) ? mem[raddr] : 8'h00;
endmodule

// File: rtl/uart_frame_rx.sv
// Framed command receiver: hunts SOF in the UART RX FIFO, assembles
// CMD/LEN/payload/XOR, hands the command over valid/ready, replies ACK/NAK.
// Optional inter-byte timeout: define UART_FRAME_RX_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int         MAX_LEN   = MAX_LEN_DEF,
    parameter int         AW        = AW_DEF,
    parameter logic [7:0] SOF_BYTE  = SOF_DEF,
    parameter logic [7:0] ACK_BYTE  = ACK_DEF,
    parameter logic [7:0] NAK_BYTE  = NAK_DEF,
    parameter int         TO_CYCLES = TO_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    uart_frame_rx_if.master bus
);
    if ((2**AW) < MAX_LEN || MAX_LEN > 255 || TO_CYCLES < 2 || TO_CYCLES > 2**TO_W) begin : g_bad_cfg
        $error("uart_frame_rx: illegal MAX_LEN/AW/TO_CYCLES combination");
    end

    state_t        state, state_nxt;
    logic          pop, nak, ack, last, frame_st, to_hit, wr;
    logic [7:0]    csum, code_q, len_q, err_q, resp_q;
    logic [AW-1:0] idx;

    assign frame_st = in_frame(state);
    // Gated by reset so no pop strobe escapes while the block is held in reset.
    assign pop  = reset && (frame_st || state == ST_IDLE) && !bus.rx_empty;
    assign last = (8'(idx) + 8'd1) == len_q;

`ifdef UART_FRAME_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                to_cnt <= '0;
        else if (!frame_st || pop) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = frame_st && bus.rx_empty && (to_cnt == TO_W'(TO_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        nak       = 1'b0;
        ack       = 1'b0;
        wr        = 1'b0;
        case (state)
            ST_IDLE: if (pop && bus.r_data == SOF_BYTE) state_nxt = ST_CMD;
            ST_CMD:  if (pop) state_nxt = ST_LEN;
            ST_LEN: begin
                if (pop) begin
                    if (bus.r_data > 8'(MAX_LEN)) nak       = 1'b1;
                    else if (bus.r_data == 8'd0)  state_nxt = ST_CSUM;
                    else                          state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (pop && last) state_nxt = ST_CSUM;
            ST_CSUM: begin
                if (pop) begin
                    if (bus.r_data == csum) state_nxt = ST_HOLD;
                    else                    nak       = 1'b1;
                end
            end
            ST_HOLD: if (bus.cmd_ready) ack = 1'b1;
            ST_RESP: begin
                if (!bus.tx_full) begin
                    wr        = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (to_hit) nak = 1'b1;
        if (nak || ack) state_nxt = ST_RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= '0;
            len_q  <= '0;
            csum   <= '0;
            idx    <= '0;
            err_q  <= '0;
            resp_q <= '0;
        end else begin
            if (pop) begin
                case (state)
                    ST_CMD: begin
                        code_q <= bus.r_data;
                        csum   <= bus.r_data;
                    end
                    ST_LEN: begin
                        len_q <= bus.r_data;
                        csum  <= csum ^ bus.r_data;
                        idx   <= '0;
                    end
                    ST_DATA: begin
                        csum <= csum ^ bus.r_data;
                        idx  <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (nak) begin
                resp_q <= NAK_BYTE;
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            end
            if (ack) resp_q <= ACK_BYTE;
        end
    end

    frame_payload_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk   (clk),
        .we    (pop && state == ST_DATA),
        .waddr (idx),
        .wdata (bus.r_data),
        .raddr (bus.pl_addr),
        .rdata (bus.pl_data)
    );

    assign bus.rd_uart   = pop;
    assign bus.wr_uart   = wr;
    assign bus.w_data    = resp_q;
    assign bus.cmd_valid = (state == ST_HOLD);
    assign bus.cmd_code  = code_q;
    assign bus.cmd_len   = len_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: table of frames with hand-computed results
// plus sequences for backpressure, latency, timeout, saturation and reset.
module tb_uart_frame_rx;
    logic clk = 1'b0;
    logic rst_n;

    uart_frame_rx_if #(.AW(4)) bus ();

    uart_frame_rx #(
        .TO_CYCLES (1000)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RX FIFO model: show-ahead head byte, popped on rd_uart.
    logic [7:0] rx_mem [256];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr = 8'd0;
    assign bus.rx_empty = (wr_ptr == rd_ptr);
    assign bus.r_data   = rx_mem[rd_ptr];
    always @(posedge clk) if (bus.rd_uart) rd_ptr <= rd_ptr + 8'd1;

    logic [7:0] tx_log [$];
    always @(posedge clk) if (bus.wr_uart) tx_log.push_back(bus.w_data);

    typedef struct {
        int         start;
        int         n;
        logic       exp_valid;
        logic [7:0] code;
        logic [7:0] len;
        logic [7:0] pl0;
        logic [7:0] pl1;
        logic [7:0] resp;
        logic [7:0] err;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] stream [$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic finish_frame(input vec_t v, input int bound);
        int base = tx_log.size();
        int t = 0;
        while (t < bound && !bus.cmd_valid && tx_log.size() == base) begin
            @(negedge clk);
            t++;
        end
        check("cmd_valid", 32'(bus.cmd_valid), 32'(v.exp_valid));
        if (bus.cmd_valid) begin
            check("cmd_code", 32'(bus.cmd_code), 32'(v.code));
            check("cmd_len", 32'(bus.cmd_len), 32'(v.len));
            if (v.len >= 8'd1) begin
                bus.pl_addr = 4'd0;
                #1 check("pl_data0", 32'(bus.pl_data), 32'(v.pl0));
            end
            if (v.len >= 8'd2) begin
                bus.pl_addr = 4'd1;
                #1 check("pl_data1", 32'(bus.pl_data), 32'(v.pl1));
            end
            bus.cmd_ready = 1'b1;
            @(negedge clk);
            bus.cmd_ready = 1'b0;
            check("valid_drop", 32'(bus.cmd_valid), 32'd0);
        end
        t = 0;
        while (t < bound && tx_log.size() == base) begin
            @(negedge clk);
            t++;
        end
        check("resp_seen", 32'(tx_log.size() > base), 32'd1);
        if (tx_log.size() > base) check("resp_byte", 32'(tx_log[base]), 32'(v.resp));
        repeat (3) @(negedge clk);
        check("resp_count", 32'(tx_log.size() - base), 32'd1);
        check("err_cnt", 32'(bus.err_cnt), 32'(v.err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   base, bad, miss;

        rst_n         = 1'b0;
        wr_ptr        = 8'd0;
        bus.tx_full   = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.pl_addr   = '0;
        repeat (3) @(negedge clk);
        push(8'hA5);
        #1;
        check("rst_rd_uart", 32'(bus.rd_uart), 32'd0);
        check("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_outputs", {bus.w_data, bus.cmd_code, bus.cmd_len, bus.err_cnt}, 32'd0);
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst_n = 1'b1;

        stream = {8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65,
                  8'hA5, 8'h10, 8'h01, 8'h55, 8'h00,
                  8'hA5, 8'h20, 8'h11,
                  8'hA5, 8'h21, 8'h00, 8'h21,
                  8'h00, 8'hFF, 8'hA5, 8'h30, 8'h00, 8'h30,
                  8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h01,
                  8'hA5, 8'h40, 8'h10};
        for (int k = 0; k < 16; k++) stream.push_back(8'(k));
        stream.push_back(8'h50);

        vecs[0] = '{0,  6,  1'b1, 8'h10, 8'h02, 8'h33, 8'h44, 8'h06, 8'h00};
        vecs[1] = '{6,  5,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h15, 8'h01};
        vecs[2] = '{11, 3,  1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h15, 8'h02};
        vecs[3] = '{14, 4,  1'b1, 8'h21, 8'h00, 8'h00, 8'h00, 8'h06, 8'h02};
        vecs[4] = '{18, 6,  1'b1, 8'h30, 8'h00, 8'h00, 8'h00, 8'h06, 8'h02};
        vecs[5] = '{24, 5,  1'b1, 8'hA5, 8'h01, 8'hA5, 8'h00, 8'h06, 8'h02};
        vecs[6] = '{29, 20, 1'b1, 8'h40, 8'h10, 8'h00, 8'h01, 8'h06, 8'h02};

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < vecs[i].n; k++) push(stream[vecs[i].start + k]);
            finish_frame(vecs[i], 200);
        end

        // Latency and HOLD backpressure.
        push(8'hA5); push(8'h30); push(8'h00); push(8'h30);
        repeat (3) @(negedge clk);
        check("latency_early", 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(bus.cmd_valid), 32'd1);
        push(8'h11); push(8'h22);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rd_uart || !bus.cmd_valid) bad++;
        end
        check("hold_no_pop", 32'(bad), 32'd0);
        check("hold_fifo_level", 32'(8'(wr_ptr - rd_ptr)), 32'd2);

        bus.tx_full   = 1'b1;
        base          = tx_log.size();
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check("bp_valid_drop", 32'(bus.cmd_valid), 32'd0);
        repeat (10) @(negedge clk);
        check("tx_full_defer", 32'(tx_log.size() - base), 32'd0);
        bus.tx_full = 1'b0;
        for (int t = 0; t < 20 && tx_log.size() == base; t++) @(negedge clk);
        check("bp_resp_seen", 32'(tx_log.size() - base), 32'd1);
        if (tx_log.size() > base) check("bp_resp_byte", 32'(tx_log[base]), 32'h06);
        repeat (5) @(negedge clk);
        check("bp_trailing_dropped", 32'(8'(wr_ptr - rd_ptr)), 32'd0);
        check("bp_err_cnt", 32'(bus.err_cnt), 32'd2);

        // Stalled partial frame.
        push(8'hA5); push(8'h10);
`ifdef UART_FRAME_RX_TIMEOUT_EN
        v = '{0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h15, 8'h03};
        finish_frame(v, 1500);
`else
        base = tx_log.size();
        repeat (300) @(negedge clk);
        check("stall_no_resp", 32'(tx_log.size() - base), 32'd0);
        check("stall_no_valid", 32'(bus.cmd_valid), 32'd0);
        push(8'h02); push(8'h33); push(8'h44); push(8'h65);
        v = '{0, 0, 1'b1, 8'h10, 8'h02, 8'h33, 8'h44, 8'h06, 8'h02};
        finish_frame(v, 200);
`endif

        // err_cnt saturation through repeated LEN-overflow frames.
        miss = 0;
        for (int k = 0; k < 260; k++) begin
            base = tx_log.size();
            push(8'hA5); push(8'h20); push(8'h11);
            for (int t = 0; t < 50 && tx_log.size() == base; t++) @(negedge clk);
            if (tx_log.size() == base) miss++;
        end
        check("sat_resp_missing", 32'(miss), 32'd0);
        check("sat_err_cnt", 32'(bus.err_cnt), 32'hFF);

        // Reset in the middle of a frame.
        push(8'hA5); push(8'h10);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_code", 32'(bus.cmd_code), 32'd0);
        check("mid_rst_err", 32'(bus.err_cnt), 32'd0);
        check("mid_rst_strobes", {bus.rd_uart, bus.wr_uart, bus.cmd_valid}, 32'd0);
        check("mid_rst_w_data", 32'(bus.w_data), 32'd0);
        base = tx_log.size();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_resp", 32'(tx_log.size() - base), 32'd0);
        for (int k = 0; k < vecs[0].n; k++) push(stream[vecs[0].start + k]);
        finish_frame(vecs[0], 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
